jump_encoder: RTL and testbench

JUMP_ENCODER -- requirements
Module: jump_encoder

---
 rtl/jump_encoder.sv | 120 ++++++++++++
 tb/tb_jump_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jump_encoder.sv
// jump_encoder: converts an absolute jump target into a J-type instruction word,
// after checking its alignment and region. Optional link opcode: JUMP_ENCODER_JAL_SUPPORT_EN.
`default_nettype none

module jump_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] target,
  input  logic [31:0] pc,
`ifdef JUMP_ENCODER_JAL_SUPPORT_EN
  input  logic        link,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] target_q;
  logic [31:0] pc_q;
  logic        link_q;
  logic        out_valid_q;
  logic [31:0] instr_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [7:0]  err_count_q;

  logic [31:0] pc_plus4;
  logic [3:0]  region;
  logic        misaligned;
  logic        out_of_region;
  logic [5:0]  opcode;
  logic        unused_pc_bits;

  // The region is the 256 MB segment of the delay-slot address, wrapping at 2^32.
  assign pc_plus4       = pc_q + 32'd4;
  assign region         = pc_plus4[31:28];
  assign unused_pc_bits = ^pc_plus4[27:0];
  assign misaligned     = (target_q[1:0] != 2'b00);
  assign out_of_region  = (target_q[31:28] != region);
  assign opcode         = link_q ? 6'b000011 : 6'b000010;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= 32'd0;
      pc_q        <= 32'd0;
      link_q      <= 1'b0;
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (in_valid) begin
            target_q <= target;
            pc_q     <= pc;
`ifdef JUMP_ENCODER_JAL_SUPPORT_EN
            link_q   <= link;
`else
            link_q   <= 1'b0;
`endif
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          if (misaligned || out_of_region) begin
            err_q       <= 1'b1;
            err_code_q  <= misaligned ? 2'b01 : 2'b10;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
            state_q     <= ERROR;
          end else begin
            instr_q     <= {opcode, target_q[27:2]};
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            state_q     <= IDLE;
          end
        end
        ERROR: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jump_encoder.sv
// tb_jump_encoder: directed checks of jump_encoder with hand-computed expectations.
`default_nettype none

module tb_jump_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] target;
  logic [31:0] pc;
  logic        link;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int checks;
  int errors;
  int seen;

  jump_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .target    (target),
    .pc        (pc),
`ifdef JUMP_ENCODER_JAL_SUPPORT_EN
    .link      (link),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_code  (err_code),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    target    = 32'd0;
    pc        = 32'd0;
    link      = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic jump, consumer always ready
    out_ready = 1'b1;
    pc = 32'h0040_0000; target = 32'h0040_0020; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("basic_check_ready", {31'd0, in_ready}, 32'd0);
    check("basic_check_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("basic_valid", {31'd0, out_valid}, 32'd1);
    check("basic_instr", instr, 32'h0810_0008);
    check("basic_err", {31'd0, err}, 32'd0);
    tick();
    check("basic_drop", {31'd0, out_valid}, 32'd0);
    check("basic_idle_ready", {31'd0, in_ready}, 32'd1);

    // Misaligned target
    target = 32'h0040_0022; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_code", {30'd0, err_code}, 32'd1);
    check("mis_count", {24'd0, err_count}, 32'd1);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("mis_err_drop", {31'd0, err}, 32'd0);
    check("mis_code_held", {30'd0, err_code}, 32'd1);
    check("mis_valid2", {31'd0, out_valid}, 32'd0);

    // Out of region: pc+4 lands in region 1
    pc = 32'h0FFF_FFFC; target = 32'h0FFF_FFF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_code", {30'd0, err_code}, 32'd2);
    check("oor_count", {24'd0, err_count}, 32'd2);
    tick();

    // Both misaligned and out of region: misaligned wins
    pc = 32'h0040_0000; target = 32'h1000_0002; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("both_code", {30'd0, err_code}, 32'd1);
    check("both_count", {24'd0, err_count}, 32'd3);
    tick();

    // pc+4 wraps to region 0; success clears err_code
    pc = 32'hFFFF_FFFC; target = 32'h0000_0010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_instr", instr, 32'h0800_0004);
    check("wrap_code_before", {30'd0, err_code}, 32'd1);
    tick();
    check("wrap_code_clear", {30'd0, err_code}, 32'd0);
    check("wrap_count_kept", {24'd0, err_count}, 32'd3);

    // Stall in HOLD while another request waits at the input
    out_ready = 1'b0;
    pc = 32'h0040_0000; target = 32'h0040_0040; in_valid = 1'b1;
    tick();
    target = 32'h0040_0080;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", instr, 32'h0810_0010);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("stall_release", {31'd0, out_valid}, 32'd0);
    check("stall_ready", {31'd0, in_ready}, 32'd1);

    // Reset asserted mid-HOLD
    out_ready = 1'b0;
    target = 32'h0040_0020; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("hold_pre_rst", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_instr", instr, 32'd0);
    check("rst_hold_err", {31'd0, err}, 32'd0);
    check("rst_hold_count", {24'd0, err_count}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_hold_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("rst_hold_no_err", {31'd0, err}, 32'd0);

    // Throughput: back-to-back requests with consumer always ready
    out_ready = 1'b1;
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    in_valid = 1'b0;
    check("throughput", seen, 32'd2);
    tick();
    tick();
    tick();

`ifdef JUMP_ENCODER_JAL_SUPPORT_EN
    link = 1'b1; target = 32'h0040_0020; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; link = 1'b0;
    tick();
    check("jal_instr", instr, 32'h0C10_0008);
    tick();
`endif

    // Saturation of the error counter
    target = 32'h0040_0001;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      if (i == 253) check("sat_count_fe", {24'd0, err_count}, 32'h0000_00FE);
      if (i == 299) check("sat_err_pulse", {31'd0, err}, 32'd1);
      tick();
    end
    check("sat_count_ff", {24'd0, err_count}, 32'h0000_00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
